speed_round_ctrl: RTL and testbench

SPEED_ROUND_CTRL -- requirements
Module: speed_round_ctrl

---
 rtl/speed_round_ctrl_pkg.sv | 29 ++
 rtl/speed_round_ctrl_tick_timer.sv | 30 +++
 rtl/speed_round_ctrl.sv | 155 +++++++++++++++
 tb/tb_speed_round_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/speed_round_ctrl_pkg.sv
// Shared types and constants for the speed round controller.
// Optional feature macro: SPEED_ROUND_COUNTDOWN_EN enables the pre-round countdown.
package speed_round_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_ROUND     = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_EVAL      = 3'd4,
      ST_EXIT      = 3'd5
   } state_t;

   localparam logic [1:0] WIN_LEFT  = 2'b00;
   localparam logic [1:0] WIN_RIGHT = 2'b01;
   localparam logic [1:0] WIN_TIE   = 2'b10;

   // Push counter stage needs one cycle for its counters and one for its comparator.
   localparam int unsigned SETTLE_CYCLES = 2;

   // Largest of three values, used to size the shared per-state counter.
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/speed_round_ctrl_tick_timer.sv
// Free-running tick divider: one-cycle tick every TICK_DIV cycles while clear is low.
module tick_timer
   import speed_round_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick_c
);

   localparam int unsigned DIV_W = $clog2(TICK_DIV + 1);

   logic [DIV_W-1:0] div_cnt;

   assign tick_c = !clear && (div_cnt == DIV_W'(TICK_DIV - 1));

   // Cycle counter, held at zero while cleared so each timed state starts aligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (clear || tick_c) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/speed_round_ctrl.sv
// Speed round sequencer: countdown, timed round, settle, evaluate, exit.
// Optional feature macro: SPEED_ROUND_COUNTDOWN_EN (countdown phase before the round).
module speed_round_ctrl
   import speed_round_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV        = 50000000,
   parameter int unsigned ROUND_TICKS     = 5,
   parameter int unsigned COUNTDOWN_TICKS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       speed_tie,
   input  logic       speed_right,
   output logic       speedRound,
   output logic       speedExit,
   output logic       busy,
   output logic       result_valid,
   output logic [1:0] winner,
   output logic [2:0] count_left
);

   localparam int unsigned CNT_MAX = max3(ROUND_TICKS, COUNTDOWN_TICKS, SETTLE_CYCLES);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_t           state;
   logic [CNT_W-1:0] state_cnt;
   logic             tick_c;
   logic             timer_clear_c;

   // Timer runs only in the tick-timed states and restarts from zero on entry.
   assign timer_clear_c = !((state == ST_COUNTDOWN) || (state == ST_ROUND));

   tick_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (timer_clear_c),
      .tick_c (tick_c)
   );

`ifdef SPEED_ROUND_COUNTDOWN_EN
   logic [2:0] count_q;
   assign count_left = count_q;
`else
   assign count_left = 3'd0;
`endif

   // Round sequencer with outputs registered on the transition into each state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         state_cnt    <= '0;
         speedRound   <= 1'b0;
         speedExit    <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         winner       <= WIN_LEFT;
`ifdef SPEED_ROUND_COUNTDOWN_EN
         count_q      <= 3'd0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state_cnt <= '0;
                  busy      <= 1'b1;
`ifdef SPEED_ROUND_COUNTDOWN_EN
                  state     <= ST_COUNTDOWN;
                  count_q   <= 3'(COUNTDOWN_TICKS);
`else
                  state      <= ST_ROUND;
                  speedRound <= 1'b1;
`endif
               end
            end
`ifdef SPEED_ROUND_COUNTDOWN_EN
            ST_COUNTDOWN: begin
               if (abort) begin
                  state     <= ST_EXIT;
                  state_cnt <= '0;
                  count_q   <= 3'd0;
                  speedExit <= 1'b1;
               end else if (tick_c) begin
                  count_q <= count_q - 3'd1;
                  if (state_cnt == CNT_W'(COUNTDOWN_TICKS - 1)) begin
                     state      <= ST_ROUND;
                     state_cnt  <= '0;
                     speedRound <= 1'b1;
                  end else begin
                     state_cnt <= state_cnt + CNT_W'(1);
                  end
               end
            end
`endif
            ST_ROUND: begin
               if (abort) begin
                  state      <= ST_EXIT;
                  state_cnt  <= '0;
                  speedRound <= 1'b0;
                  speedExit  <= 1'b1;
               end else if (tick_c) begin
                  if (state_cnt == CNT_W'(ROUND_TICKS - 1)) begin
                     state      <= ST_SETTLE;
                     state_cnt  <= '0;
                     speedRound <= 1'b0;
                  end else begin
                     state_cnt <= state_cnt + CNT_W'(1);
                  end
               end
            end
            ST_SETTLE: begin
               if (state_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                  state     <= ST_EVAL;
                  state_cnt <= '0;
               end else begin
                  state_cnt <= state_cnt + CNT_W'(1);
               end
            end
            ST_EVAL: begin
               // Tie outranks a right-side win.
               if (speed_tie) begin
                  winner <= WIN_TIE;
               end else if (speed_right) begin
                  winner <= WIN_RIGHT;
               end else begin
                  winner <= WIN_LEFT;
               end
               state        <= ST_EXIT;
               state_cnt    <= '0;
               speedExit    <= 1'b1;
               result_valid <= 1'b1;
            end
            ST_EXIT: begin
               state        <= ST_IDLE;
               state_cnt    <= '0;
               speedExit    <= 1'b0;
               result_valid <= 1'b0;
               busy         <= 1'b0;
            end
            default: begin
               state        <= ST_IDLE;
               state_cnt    <= '0;
               speedRound   <= 1'b0;
               speedExit    <= 1'b0;
               result_valid <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_speed_round_ctrl.sv
// Directed bench for speed_round_ctrl (TICK_DIV=4, ROUND_TICKS=3, COUNTDOWN_TICKS=2).
// Expectations follow SPEED_ROUND_COUNTDOWN_EN as seen by this compilation.
module tb_speed_round_ctrl;

`ifdef SPEED_ROUND_COUNTDOWN_EN
   localparam int CD_CYC = 8;
`else
   localparam int CD_CYC = 0;
`endif
   localparam int RND_CYC = 12;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic       speed_tie;
   logic       speed_right;
   logic       speedRound;
   logic       speedExit;
   logic       busy;
   logic       result_valid;
   logic [1:0] winner;
   logic [2:0] count_left;

   int n_cmp = 0;
   int n_err = 0;

   speed_round_ctrl #(
      .TICK_DIV        (4),
      .ROUND_TICKS     (3),
      .COUNTDOWN_TICKS (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .speed_tie    (speed_tie),
      .speed_right  (speed_right),
      .speedRound   (speedRound),
      .speedExit    (speedExit),
      .busy         (busy),
      .result_valid (result_valid),
      .winner       (winner),
      .count_left   (count_left)
   );

   always #5 clk = ~clk;

   // Advance one cycle and land just after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Full round from IDLE; optionally keeps start high or holds abort from SETTLE onward.
   task automatic run_round(input logic [1:0] exp_win, input bit hold_start, input bit late_abort);
      start = 1'b1;
      step();
      start = hold_start;
      for (int i = 0; i < CD_CYC; i++) begin
         check("cd_busy", 32'(busy), 1);
         check("cd_speedround", 32'(speedRound), 0);
         check("cd_count_left", 32'(count_left), (i < 4) ? 2 : 1);
         step();
      end
      for (int i = 0; i < RND_CYC; i++) begin
         check("rnd_speedround", 32'(speedRound), 1);
         check("rnd_busy", 32'(busy), 1);
         check("rnd_count_left", 32'(count_left), 0);
         check("rnd_speedexit", 32'(speedExit), 0);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         abort = late_abort;
         check("settle_speedround", 32'(speedRound), 0);
         check("settle_busy", 32'(busy), 1);
         check("settle_speedexit", 32'(speedExit), 0);
         check("settle_valid", 32'(result_valid), 0);
         step();
      end
      check("exit_speedexit", 32'(speedExit), 1);
      check("exit_valid", 32'(result_valid), 1);
      check("exit_winner", 32'(winner), 32'(exp_win));
      check("exit_busy", 32'(busy), 1);
      step();
      abort = 1'b0;
      check("idle_busy", 32'(busy), 0);
      check("idle_speedexit", 32'(speedExit), 0);
      check("idle_valid", 32'(result_valid), 0);
      check("idle_winner_hold", 32'(winner), 32'(exp_win));
   endtask

   // Start a round and stop at the first ROUND cycle.
   task automatic enter_round();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (CD_CYC) step();
      check("enter_round", 32'(speedRound), 1);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      speed_tie = 1'b0;
      speed_right = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_speedround", 32'(speedRound), 0);
      check("rst_speedexit", 32'(speedExit), 0);
      check("rst_valid", 32'(result_valid), 0);
      check("rst_winner", 32'(winner), 0);
      check("rst_count_left", 32'(count_left), 0);
      @(negedge clk);
      rst = 1'b1;
      step();

      // Right wins, left wins with abort ignored late, tie outranks right.
      speed_right = 1'b1; speed_tie = 1'b0;
      run_round(2'b01, 1'b0, 1'b0);
      step();
      speed_right = 1'b0; speed_tie = 1'b0;
      run_round(2'b00, 1'b0, 1'b1);
      step();
      speed_right = 1'b1; speed_tie = 1'b1;
      run_round(2'b10, 1'b0, 1'b0);
      step();

      // Abort at the 5th ROUND cycle.
      enter_round();
      repeat (4) step();
      check("abort_pre_speedround", 32'(speedRound), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_speedround", 32'(speedRound), 0);
      check("abort_speedexit", 32'(speedExit), 1);
      check("abort_valid", 32'(result_valid), 0);
      check("abort_winner", 32'(winner), 2);
      step();
      check("abort_idle_busy", 32'(busy), 0);
      check("abort_idle_valid", 32'(result_valid), 0);
      check("abort_idle_winner", 32'(winner), 2);
      step();

      // Reset at the 7th ROUND cycle takes effect without an edge.
      enter_round();
      repeat (6) step();
      rst = 1'b0;
      #1;
      check("midrst_speedround", 32'(speedRound), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_speedexit", 32'(speedExit), 0);
      check("midrst_valid", 32'(result_valid), 0);
      check("midrst_winner", 32'(winner), 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("postrst_busy", 32'(busy), 0);
         check("postrst_speedexit", 32'(speedExit), 0);
         check("postrst_speedround", 32'(speedRound), 0);
      end

      // Start held high: one IDLE cycle, then the next round begins.
      speed_right = 1'b1; speed_tie = 1'b0;
      run_round(2'b01, 1'b1, 1'b0);
      step();
      check("b2b_busy", 32'(busy), 1);
`ifdef SPEED_ROUND_COUNTDOWN_EN
      check("b2b_count_left", 32'(count_left), 2);
      check("b2b_speedround", 32'(speedRound), 0);
`else
      check("b2b_count_left", 32'(count_left), 0);
      check("b2b_speedround", 32'(speedRound), 1);
`endif
      start = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("b2b_abort_speedexit", 32'(speedExit), 1);
      check("b2b_abort_valid", 32'(result_valid), 0);
      check("b2b_abort_speedround", 32'(speedRound), 0);
      check("b2b_abort_winner", 32'(winner), 1);
      step();
      check("b2b_idle_busy", 32'(busy), 0);
      check("b2b_idle_count_left", 32'(count_left), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
